// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-step counter width; counts 0 .. width-1.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell, reused once per bit step by serial_adder.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, valid/ready result handshake.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Subtraction is a + ~b + 1; the inverted operand and forced carry are applied at load.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load     = b;
    carry_load = cin;
  end
`endif

  serial_adder_fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // The newest sum bit enters at the top, so after WIDTH steps bit 0 lands in place.
  assign sum_next = {fa_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_next[WIDTH-1:1];
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ fa_c;
          cout_d  = fa_c;
          sum_d   = sum_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q == RUN);
    res_valid   = (state_q == DONE);
    sum         = sum_q;
    cout        = cout_q;
    ovf         = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH = 8): directed vectors, decoupled result monitor.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_edge = 0;
  logic rv_prev = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub         (sub),
`endif
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: latency on res_valid rise, scoreboard pop on each result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (start_valid && start_ready) accept_edge = cyc + 1;
      if (res_valid && !rv_prev) check("latency", cyc - accept_edge, WIDTH);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum", {24'd0, sum}, {24'd0, e.sum});
          check("cout", {31'd0, cout}, {31'd0, e.cout});
          check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        end
      end
    end
    rv_prev = res_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic isub, input logic push, input logic [7:0] esum,
                       input logic ecout, input logic eovf);
    int n = 0;
    while (!start_ready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) check("start_ready timeout", 32'd0, 32'd1);
    start_valid = 1'b1;
    a   = ia;
    b   = ib;
    cin = icin;
    sub = isub;
    if (push) exp_q.push_back('{sum: esum, cout: ecout, ovf: eovf});
    step();
    start_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (n == 100) check("drain timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    res_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst start_ready", {31'd0, start_ready}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst res_valid", {31'd0, res_valid}, 32'd0);
    check("rst sum", {24'd0, sum}, 32'd0);
    check("rst cout", {31'd0, cout}, 32'd0);
    check("rst ovf", {31'd0, ovf}, 32'd0);
    step();
    rst = 1'b0;
    step();

    issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    drain();
    issue(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    drain();
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    drain();
    issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    drain();
    issue(8'hAA, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    drain();

    // Stall: result held with res_ready low while start_valid stays asserted.
    res_ready = 1'b0;
    issue(8'h3C, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
    n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("res_valid timeout", 32'd0, 32'd1);
    start_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall start_ready", {31'd0, start_ready}, 32'd0);
      check("stall res_valid", {31'd0, res_valid}, 32'd1);
      check("stall busy", {31'd0, busy}, 32'd0);
      check("stall sum", {24'd0, sum}, 32'h46);
      step();
    end
    res_ready = 1'b1;
    start_valid = 1'b0;
    step();
    check("post handshake start_ready", {31'd0, start_ready}, 32'd1);
    check("post handshake res_valid", {31'd0, res_valid}, 32'd0);
    drain();

    // Reset on the third RUN edge aborts the operation without a result.
    issue(8'h55, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort res_valid", {31'd0, res_valid}, 32'd0);
    check("abort start_ready", {31'd0, start_ready}, 32'd1);
    check("abort sum", {24'd0, sum}, 32'd0);
    step();
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
    drain();

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    drain();
    issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that time-multiplexes a single 1-bit full-adder cell over WIDTH clock cycles, LSB first. It holds the carry in a flip-flop between bit steps and returns the full sum, carry-out and signed-overflow flag through a valid/ready result handshake. It sits directly upstream of the full-adder cell, sequencing its operands and consuming its Sum/Cout each cycle. It is the area-minimal adder option for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start_valid  input  1  operands a/b/cin present.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high in RUN.
- res_valid  output  1  sum/cout/ovf valid; high only in DONE.
- res_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: a_sh <= a; b_sh <= b; carry <= cin; cnt <= 0; go to RUN.
- RUN: the cell computes a_sh[0] + b_sh[0] + carry. Each cycle:
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry <= c; cnt <= cnt + 1.
  - When cnt == WIDTH-1: ovf <= carry ^ c; cout <= c; sum <= {s, sum_sh[WIDTH-1:1]}; go to DONE.
- DONE:
  - res_valid = 1. sum, cout and ovf hold stable.
  - start_valid is ignored because start_ready = 0.
  - On res_ready: go to IDLE. sum, cout and ovf keep their last values until the next completion.
- Arithmetic: {cout, sum} = a + b + cin modulo 2^(WIDTH+1). No truncation beyond that.
- Reset, from any state including mid-RUN: next state is IDLE and the operation is aborted with no result emitted. Reset values:
  - start_ready = 1
  - busy = 0, res_valid = 0
  - sum = 0, cout = 0, ovf = 0
  - carry = 0, cnt = 0

## Timing
- Operand acceptance edge is edge T.
- RUN occupies edges T+1 … T+WIDTH.
- res_valid is high after edge T+WIDTH, i.e. WIDTH cycles of latency.
- If res_ready is already high when res_valid rises, DONE lasts 1 cycle. start_ready returns high the cycle after the result handshake.
- Minimum issue interval is WIDTH+2 cycles. There is no overlap of operations.
- start_ready, busy and res_valid are decoded from state (Moore). No combinational path runs from start_valid or res_ready to any output.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - The sub port exists and is sampled at acceptance.
  - sub = 1 loads b_sh <= ~b and carry <= 1, and cin is ignored. Result: sum = a - b, with cout = 1 meaning no borrow, and ovf = signed overflow of the subtraction.
  - sub = 0 behaves exactly as an add.
- Undefined: the sub port is absent and the block is add-only.

## Structure
- Shared package serial_adder_pkg holds:
  - State encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - A counter-width function returning clog2(WIDTH).
- One sub-module: fa, the 1-bit full adder (A, B, Cin -> Sum, Cout), instantiated exactly once. The bench checks its outputs as s/c of the step.

## Test plan
All scenarios use WIDTH = 8.
- a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0, ovf=0; res_valid exactly 8 cycles after the acceptance edge.
- a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- Result complete with res_ready held low 5 cycles and start_valid=1 throughout -> sum/cout/ovf stable, start_ready=0, no new operand accepted; raising res_ready -> IDLE next cycle.
- rst pulsed on the 3rd RUN cycle -> next cycle state IDLE, busy=0, res_valid=0, start_ready=1, sum=0. A follow-up a=8'h12, b=8'h34 -> sum=8'h46.
- SERIAL_ADDER_SUB_EN defined, sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0. Then sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
